// File: rtl/mac_tx_pkg.sv
// Shared types and defaults for the MAC transmit arbiter and related schedulers.
// Pure declarations: no logic, no latency, no flow control.
package mac_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FWD   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int MAX_BEATS_DEF = 1518;
    localparam int CNT_W_DEF     = 32;

endpackage

// File: rtl/mac_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req at ptr, ptr+1, ... mod N, as one-hot.
// Zero latency; no flow control (vld_o flags that any request was present).
module rr_pick
    import mac_tx_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic          vld_o
);

    logic [N-1:0] rot;
    logic [N-1:0] oh;

    // Rotate so the pointer position is bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        rot = '0;
        for (int p = 0; p < N; p++) begin
            if (ptr_i == PW'(p)) begin
                for (int j = 0; j < N; j++) begin
                    rot[j] = req_i[(p + j) % N];
                end
            end
        end
        oh      = rot & (~rot + N'(1));
        grant_o = '0;
        for (int p = 0; p < N; p++) begin
            if (ptr_i == PW'(p)) begin
                for (int j = 0; j < N; j++) begin
                    grant_o[(p + j) % N] = oh[j];
                end
            end
        end
    end

    assign vld_o = |req_i;

endmodule

// File: rtl/mac_tx_arbiter.sv
// Frame-level round-robin arbiter onto the MAC tx client port; 1-cycle arbitration, then s_* -> m_* combinational.
// Backpressure: m_tready passes straight to the granted source; over-length frames are cut with tuser and drained.
module mac_tx_arbiter
    import mac_tx_pkg::*;
#(
    parameter int NUM_SRC   = 2,
    parameter int MAX_BEATS = MAX_BEATS_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SRC-1:0]   src_en,
    input  logic [8*NUM_SRC-1:0] s_tdata,
    input  logic [NUM_SRC-1:0]   s_tvalid,
    input  logic [NUM_SRC-1:0]   s_tlast,
    input  logic [NUM_SRC-1:0]   s_tuser,
    output logic [NUM_SRC-1:0]   s_tready,
    output logic [7:0]           m_tdata,
    output logic                 m_tvalid,
    output logic                 m_tlast,
    output logic                 m_tuser,
    input  logic                 m_tready,
    output logic [NUM_SRC-1:0]   grant,
    output logic                 busy,
    output logic [CNT_W-1:0]     frame_cnt,
    output logic [CNT_W-1:0]     trunc_cnt
);

    localparam int PW = $clog2(NUM_SRC);
    localparam int BW = $clog2(MAX_BEATS + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BEATS - 1);

    state_t               state_q;
    logic [NUM_SRC-1:0]   grant_q;
    logic [PW-1:0]        gidx_q;
    logic [PW-1:0]        rr_ptr_q;
    logic [PW-1:0]        rr_ptr_d;
    logic [BW-1:0]        beat_cnt_q;
    logic [CNT_W-1:0]     frame_cnt_q;
    logic [CNT_W-1:0]     trunc_cnt_q;

    logic [NUM_SRC-1:0]   pick_grant;
    logic                 pick_vld;
    logic [PW-1:0]        pick_idx;
    logic [7:0]           g_data;
    logic                 g_vld;
    logic                 g_last;
    logic                 g_user;
    logic                 at_limit;
    logic                 hs;

    rr_pick #(.N(NUM_SRC), .PW(PW)) u_pick (
        .req_i   (s_tvalid & src_en),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_grant),
        .vld_o   (pick_vld)
    );

    always_comb begin
        pick_idx = '0;
        g_data   = '0;
        g_vld    = 1'b0;
        g_last   = 1'b0;
        g_user   = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pick_grant[i]) pick_idx = PW'(i);
            if (gidx_q == PW'(i)) begin
                g_data = s_tdata[8*i +: 8];
                g_vld  = s_tvalid[i];
                g_last = s_tlast[i];
                g_user = s_tuser[i];
            end
        end
    end

    // The beat that reaches MAX_BEATS without tlast is closed off as an aborted frame.
    assign at_limit = (beat_cnt_q == LAST_BEAT) && !g_last;
    assign hs       = (state_q == FWD) && g_vld && m_tready;
    assign rr_ptr_d = (gidx_q == PW'(NUM_SRC - 1)) ? '0 : gidx_q + PW'(1);

    always_comb begin
        m_tdata  = '0;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        m_tuser  = 1'b0;
        s_tready = '0;
        if (state_q == FWD) begin
            m_tdata  = g_data;
            m_tvalid = g_vld;
            m_tlast  = g_last | at_limit;
            m_tuser  = g_user | at_limit;
            s_tready = grant_q & {NUM_SRC{m_tready}};
        end else if (state_q == DRAIN) begin
            s_tready = grant_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            gidx_q      <= '0;
            rr_ptr_q    <= '0;
            beat_cnt_q  <= '0;
            frame_cnt_q <= '0;
            trunc_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        grant_q    <= pick_grant;
                        gidx_q     <= pick_idx;
                        beat_cnt_q <= '0;
                        state_q    <= FWD;
                    end
                end
                FWD: begin
                    if (hs) begin
                        if (beat_cnt_q != {BW{1'b1}}) beat_cnt_q <= beat_cnt_q + BW'(1);
                        if (g_last) begin
                            frame_cnt_q <= frame_cnt_q + CNT_W'(1);
                            rr_ptr_q    <= rr_ptr_d;
                            grant_q     <= '0;
                            state_q     <= IDLE;
                        end else if (at_limit) begin
                            trunc_cnt_q <= trunc_cnt_q + CNT_W'(1);
                            state_q     <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (g_vld && g_last) begin
                        rr_ptr_q <= rr_ptr_d;
                        grant_q  <= '0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant     = grant_q;
    assign busy      = (state_q != IDLE);
    assign frame_cnt = frame_cnt_q;
    assign trunc_cnt = trunc_cnt_q;

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Scoreboarded bench for mac_tx_arbiter: dut0 uses the default frame limit, dut1 a limit of 16 beats.
module tb_mac_tx_arbiter;

    typedef struct {
        int         d;
        logic [7:0] data;
        logic       last;
        logic       user;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst      [2];
    logic [1:0]  src_en   [2];
    logic [7:0]  tdat     [2][2];
    logic        tvld     [2][2];
    logic        tlst     [2][2];
    logic        tusr     [2][2];
    logic [15:0] s_tdata  [2];
    logic [1:0]  s_tvalid [2];
    logic [1:0]  s_tlast  [2];
    logic [1:0]  s_tuser  [2];
    logic [1:0]  s_tready [2];
    logic [7:0]  m_tdata  [2];
    logic        m_tvalid [2];
    logic        m_tlast  [2];
    logic        m_tuser  [2];
    logic        m_tready [2];
    logic [1:0]  grant    [2];
    logic        busy     [2];
    logic [31:0] frame_cnt[2];
    logic [31:0] trunc_cnt[2];

    beat_t exp_q[$];
    int    n_cmp  = 0;
    int    n_fail = 0;
    int    drained1 = 0;
    bit    bp_chk = 0;
    bit    oh_chk = 0;
    bit    bp_run = 0;

    always #5 clk = ~clk;

    for (genvar d = 0; d < 2; d++) begin : g_pack
        assign s_tdata[d]  = {tdat[d][1], tdat[d][0]};
        assign s_tvalid[d] = {tvld[d][1], tvld[d][0]};
        assign s_tlast[d]  = {tlst[d][1], tlst[d][0]};
        assign s_tuser[d]  = {tusr[d][1], tusr[d][0]};
    end

    mac_tx_arbiter #(.NUM_SRC(2), .MAX_BEATS(1518), .CNT_W(32)) dut0 (
        .clk(clk), .rst(rst[0]), .src_en(src_en[0]),
        .s_tdata(s_tdata[0]), .s_tvalid(s_tvalid[0]), .s_tlast(s_tlast[0]), .s_tuser(s_tuser[0]),
        .s_tready(s_tready[0]),
        .m_tdata(m_tdata[0]), .m_tvalid(m_tvalid[0]), .m_tlast(m_tlast[0]), .m_tuser(m_tuser[0]),
        .m_tready(m_tready[0]),
        .grant(grant[0]), .busy(busy[0]), .frame_cnt(frame_cnt[0]), .trunc_cnt(trunc_cnt[0])
    );

    mac_tx_arbiter #(.NUM_SRC(2), .MAX_BEATS(16), .CNT_W(32)) dut1 (
        .clk(clk), .rst(rst[1]), .src_en(src_en[1]),
        .s_tdata(s_tdata[1]), .s_tvalid(s_tvalid[1]), .s_tlast(s_tlast[1]), .s_tuser(s_tuser[1]),
        .s_tready(s_tready[1]),
        .m_tdata(m_tdata[1]), .m_tvalid(m_tvalid[1]), .m_tlast(m_tlast[1]), .m_tuser(m_tuser[1]),
        .m_tready(m_tready[1]),
        .grant(grant[1]), .busy(busy[1]), .frame_cnt(frame_cnt[1]), .trunc_cnt(trunc_cnt[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected MAC beats; trunc_at>0 cuts the frame there with tlast=1, tuser=1.
    task automatic push_frame(input int d, input int len, input int base, input int trunc_at);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d    = d;
            b.data = 8'(base + i);
            b.last = (i == len - 1);
            b.user = 1'b0;
            if (trunc_at > 0 && i == trunc_at - 1) begin
                b.last = 1'b1;
                b.user = 1'b1;
                exp_q.push_back(b);
                break;
            end
            exp_q.push_back(b);
        end
    endtask

    // Source driver: byte i = base+i, tlast on the final byte; returns negedges waited for beat 0.
    task automatic send(input int d, input int s, input int len, input int base, output int first_wait);
        first_wait = 0;
        for (int i = 0; i < len; i++) begin
            int waits;
            bit hs;
            waits = 0;
            hs    = 1'b0;
            tvld[d][s] = 1'b1;
            tdat[d][s] = 8'(base + i);
            tlst[d][s] = (i == len - 1);
            tusr[d][s] = 1'b0;
            while (!hs && waits < 2000) begin
                @(negedge clk);
                hs = s_tready[d][s];
                waits++;
                @(posedge clk);
                #1;
            end
            if (!hs) begin
                n_cmp++;
                n_fail++;
                $display("FAIL send_timeout dut%0d src%0d beat %0d: no s_tready, required within 2000 cycles", d, s, i);
                tvld[d][s] = 1'b0;
                return;
            end
            if (i == 0) first_wait = waits;
        end
        tvld[d][s] = 1'b0;
        tlst[d][s] = 1'b0;
    endtask

    always @(negedge clk) begin
        beat_t e;
        for (int d = 0; d < 2; d++) begin
            if (m_tvalid[d] && m_tready[d]) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_beat dut%0d: got data=%02h last=%0b user=%0b, expected none",
                             d, m_tdata[d], m_tlast[d], m_tuser[d]);
                end else begin
                    e = exp_q.pop_front();
                    if (e.d != d || m_tdata[d] !== e.data || m_tlast[d] !== e.last || m_tuser[d] !== e.user) begin
                        n_fail++;
                        $display("FAIL beat dut%0d: got data=%02h last=%0b user=%0b, expected dut%0d data=%02h last=%0b user=%0b",
                                 d, m_tdata[d], m_tlast[d], m_tuser[d], e.d, e.data, e.last, e.user);
                    end
                end
            end
        end
        if (bp_chk && grant[0] != 2'b00)
            chk("s_tready_tracks_m_tready", s_tready[0], grant[0] & {2{m_tready[0]}});
        if (oh_chk && m_tvalid[0])
            chk("grant_onehot", $onehot(grant[0]), 1);
        if (grant[1] != 2'b00 && !m_tvalid[1] && (s_tready[1] & s_tvalid[1]) != 2'b00)
            drained1++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int fw0, fw1, fwa, fwb;
        for (int d = 0; d < 2; d++) begin
            rst[d]      = 1'b1;
            src_en[d]   = 2'b11;
            m_tready[d] = 1'b1;
            for (int s = 0; s < 2; s++) begin
                tdat[d][s] = '0;
                tvld[d][s] = 1'b0;
                tlst[d][s] = 1'b0;
                tusr[d][s] = 1'b0;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant",     grant[0],     0);
        chk("rst_busy",      busy[0],      0);
        chk("rst_m_tvalid",  m_tvalid[0],  0);
        chk("rst_m_tdata",   m_tdata[0],   0);
        chk("rst_s_tready",  s_tready[0],  0);
        chk("rst_frame_cnt", frame_cnt[0], 0);
        chk("rst_trunc_cnt", trunc_cnt[0], 0);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(posedge clk);
        #1;

        // Single source, 64 bytes.
        push_frame(0, 64, 8'h00, 0);
        send(0, 0, 64, 8'h00, fw0);
        chk("first_beat_latency", fw0, 2);
        repeat (2) @(posedge clk);
        #1;
        chk("single_frame_cnt", frame_cnt[0], 1);

        // Backpressure on a 60-byte frame from src1 (rr_ptr now 1).
        push_frame(0, 60, 8'h40, 0);
        bp_chk = 1'b1;
        bp_run = 1'b1;
        fork
            begin
                send(0, 1, 60, 8'h40, fw1);
                bp_run = 1'b0;
            end
            begin
                while (bp_run) begin
                    @(posedge clk);
                    #1;
                    m_tready[0] = ~m_tready[0];
                end
            end
        join
        bp_chk = 1'b0;
        m_tready[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("bp_frame_cnt", frame_cnt[0], 2);

        // Contention: three 100-byte frames per source, expected strict alternation from src0.
        for (int f = 0; f < 3; f++) begin
            push_frame(0, 100, 16 * f, 0);
            push_frame(0, 100, 8'h80 + 16 * f, 0);
        end
        oh_chk = 1'b1;
        fork
            for (int f = 0; f < 3; f++) send(0, 0, 100, 16 * f, fw0);
            for (int f = 0; f < 3; f++) send(0, 1, 100, 8'h80 + 16 * f, fw1);
        join
        oh_chk = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("contention_frame_cnt", frame_cnt[0], 8);
        chk("contention_trunc_cnt", trunc_cnt[0], 0);

        // Enable mask: src0 requests but is masked; only src1 is served.
        src_en[0]  = 2'b10;
        tvld[0][0] = 1'b1;
        tdat[0][0] = 8'h55;
        tlst[0][0] = 1'b0;
        push_frame(0, 4, 8'hC0, 0);
        send(0, 1, 4, 8'hC0, fw1);
        repeat (3) @(posedge clk);
        #1;
        chk("mask_grant_idle", grant[0],    0);
        chk("mask_s_tready",   s_tready[0], 0);
        chk("mask_frame_cnt",  frame_cnt[0], 9);

        // Unmask, hold the MAC off, then reset mid-frame.
        m_tready[0] = 1'b0;
        src_en[0]   = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        chk("unmask_grant",    grant[0],    2'b01);
        chk("unmask_busy",     busy[0],     1);
        chk("unmask_m_tvalid", m_tvalid[0], 1);
        tvld[0][1] = 1'b1;
        tdat[0][1] = 8'h66;
        #2;
        rst[0] = 1'b1;
        #1;
        chk("midrst_grant",     grant[0],     0);
        chk("midrst_busy",      busy[0],      0);
        chk("midrst_m_tvalid",  m_tvalid[0],  0);
        chk("midrst_s_tready",  s_tready[0],  0);
        chk("midrst_frame_cnt", frame_cnt[0], 0);
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_grant_src0", grant[0], 2'b01);
        tvld[0][0] = 1'b0;
        tvld[0][1] = 1'b0;

        // dut1 (limit 16): 40-byte src1 frame truncated, src0 next, then an exact 16-byte src1 frame.
        push_frame(1, 40, 8'h10, 16);
        push_frame(1, 8,  8'hA0, 0);
        push_frame(1, 16, 8'h30, 0);
        fork
            begin
                send(1, 1, 40, 8'h10, fwa);
                send(1, 1, 16, 8'h30, fwa);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                send(1, 0, 8, 8'hA0, fwb);
            end
            begin
                repeat (30) @(posedge clk);
                #1;
                chk("drain_frame_cnt", frame_cnt[1], 0);
                chk("drain_trunc_cnt", trunc_cnt[1], 1);
                chk("drain_m_tvalid",  m_tvalid[1],  0);
            end
        join
        repeat (2) @(posedge clk);
        #1;
        chk("trunc_drained_beats", drained1,     24);
        chk("trunc_final_trunc",   trunc_cnt[1], 1);
        chk("trunc_final_frames",  frame_cnt[1], 2);

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
